// File: rtl/multicore_pkg.sv
// Shared writeback types: load-size encoding, result-source indices and core sizing constants.
package multicore_pkg;

  localparam int DATA_SIZE = 32;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10
  } wb_ldsize_t;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_MEM = 1;
  localparam int WB_SRC_PC  = 2;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small FIFO holding writeback entries; pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module wb_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: buffers entries, selects the result source and optionally extends loads.
// Load extension is built only when macro WB_LOADEXT_EN is defined.
module writeback_pipe
  import multicore_pkg::*;
#(
  parameter int NSRC   = 3,
  parameter int DATA_W = DATA_SIZE,
  parameter int DEPTH  = 2,
  parameter int LD_SRC = WB_SRC_MEM
) (
  input  logic                        i_aclk,
  input  logic                        i_areset_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [$clog2(NUM_REGS)-1:0] i_rdest,
  input  logic                        i_regwrite,
  input  logic [$clog2(NSRC)-1:0]     i_sel,
  input  logic [NSRC*DATA_W-1:0]      i_src_data,
  input  logic [1:0]                  i_ld_size,
  input  logic                        i_ld_unsigned,
  input  logic [1:0]                  i_ld_offset,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [$clog2(NUM_REGS)-1:0] o_rdest,
  output logic                        o_regwrite,
  output logic [DATA_W-1:0]           o_wb_result,
  output logic                        o_sel_err,
  output logic [31:0]                 o_retire_cnt
);

  localparam int RW  = $clog2(NUM_REGS);
  localparam int SW  = $clog2(NSRC);
  localparam int SDW = NSRC * DATA_W;
`ifdef WB_LOADEXT_EN
  localparam int EW  = RW + 1 + SW + SDW + 5;
`else
  localparam int EW  = RW + 1 + SW + SDW;
`endif

  logic [EW-1:0]     wdata;
  logic [EW-1:0]     rdata;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [RW-1:0]     head_rdest;
  logic              head_regwrite;
  logic [SW-1:0]     head_sel;
  logic [SDW-1:0]    head_src;
  logic              sel_bad;
  logic [DATA_W-1:0] picked;
  logic [DATA_W-1:0] result_ext;
  logic [31:0]       retire_cnt;

  function automatic logic [DATA_W-1:0] ld_extend(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size,
                                                  input logic uns,
                                                  input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = d[16*off[1] +: 16];
    case (wb_ldsize_t'(size))
      LD_B:    return uns ? {{(DATA_W-8){1'b0}}, b} : {{(DATA_W-8){b[7]}}, b};
      LD_H:    return uns ? {{(DATA_W-16){1'b0}}, h} : {{(DATA_W-16){h[15]}}, h};
      default: return d;
    endcase
  endfunction

  assign o_ready = ~full;
  assign o_valid = ~empty;
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

`ifdef WB_LOADEXT_EN
  logic [1:0] head_ld_size;
  logic       head_ld_uns;
  logic [1:0] head_ld_off;

  assign wdata = {i_ld_size, i_ld_unsigned, i_ld_offset, i_src_data, i_sel, i_regwrite, i_rdest};
  assign head_ld_size = rdata[EW-1 -: 2];
  assign head_ld_uns  = rdata[EW-3];
  assign head_ld_off  = rdata[EW-4 -: 2];
`else
  logic unused_ld;

  // Load fields are neither stored nor used when extension is compiled out.
  assign wdata     = {i_src_data, i_sel, i_regwrite, i_rdest};
  assign unused_ld = ^{i_ld_size, i_ld_unsigned, i_ld_offset};
`endif

  wb_skid_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_aclk),
    .rst_n (i_areset_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign head_rdest    = rdata[RW-1:0];
  assign head_regwrite = rdata[RW];
  assign head_sel      = rdata[RW+1 +: SW];
  assign head_src      = rdata[RW+1+SW +: SDW];
  assign sel_bad       = (int'(head_sel) >= NSRC);

  always_comb begin
    picked = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(head_sel) == k) picked = head_src[k*DATA_W +: DATA_W];
    end
  end

`ifdef WB_LOADEXT_EN
  assign result_ext = (int'(head_sel) == LD_SRC)
                    ? ld_extend(picked, head_ld_size, head_ld_uns, head_ld_off) : picked;
`else
  assign result_ext = picked;
`endif

  assign o_rdest     = head_rdest;
  assign o_regwrite  = o_valid & head_regwrite & (head_rdest != '0);
  assign o_sel_err   = o_valid & sel_bad;
  assign o_wb_result = (o_valid && !sel_bad) ? result_ext : '0;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) retire_cnt <= '0;
    else if (pop)    retire_cnt <= retire_cnt + 32'd1;
  end

  assign o_retire_cnt = retire_cnt;

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe with default parameters (NSRC=3, DATA_W=32, DEPTH=2).
module tb_writeback_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  rdest_in;
  logic        regwrite_in;
  logic [1:0]  sel_in;
  logic [95:0] src_in;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [1:0]  ld_off;
  logic        valid_out;
  logic        ready_in;
  logic [4:0]  rdest_out;
  logic        regwrite_out;
  logic [31:0] result;
  logic        sel_err;
  logic [31:0] retire_cnt;

  int checks = 0;
  int passed = 0;

  writeback_pipe dut (
    .i_aclk        (clk),
    .i_areset_n    (rst_n),
    .i_valid       (valid_in),
    .o_ready       (ready_out),
    .i_rdest       (rdest_in),
    .i_regwrite    (regwrite_in),
    .i_sel         (sel_in),
    .i_src_data    (src_in),
    .i_ld_size     (ld_size),
    .i_ld_unsigned (ld_uns),
    .i_ld_offset   (ld_off),
    .o_valid       (valid_out),
    .i_ready       (ready_in),
    .o_rdest       (rdest_out),
    .o_regwrite    (regwrite_out),
    .o_wb_result   (result),
    .o_sel_err     (sel_err),
    .o_retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] s,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                       input logic [1:0] sz, input logic u, input logic [1:0] off);
    valid_in    = v;
    rdest_in    = rd;
    regwrite_in = rw;
    sel_in      = s;
    src_in      = {pc, mem, alu};
    ld_size     = sz;
    ld_uns      = u;
    ld_off      = off;
  endtask

  initial begin
    logic [31:0] exp_b3s;
    logic [31:0] exp_h2u;
`ifdef WB_LOADEXT_EN
    exp_b3s = 32'hFFFF_FF80;
    exp_h2u = 32'h0000_80F0;
`else
    exp_b3s = 32'h80F0_7F81;
    exp_h2u = 32'h80F0_7F81;
`endif
    rst_n    = 1'b0;
    ready_in = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick; tick;
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_ready", {31'b0, ready_out}, 32'd1);
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_regwrite", {31'b0, regwrite_out}, 32'd0);
    check("rst_selerr", {31'b0, sel_err}, 32'd0);
    rst_n = 1'b1;

    // Single push into an empty buffer, consumer ready.
    ready_in = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 2'd0, 32'h1234, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    check("single_valid", {31'b0, valid_out}, 32'd1);
    check("single_result", result, 32'h1234);
    check("single_regwrite", {31'b0, regwrite_out}, 32'd1);
    check("single_rdest", {27'b0, rdest_out}, 32'd5);
    check("single_cnt_before", retire_cnt, 32'd0);
    tick;
    check("single_cnt_after", retire_cnt, 32'd1);
    check("single_empty", {31'b0, valid_out}, 32'd0);
    check("empty_result", result, 32'd0);

    // Loads: byte off 3 signed, then half off 2 unsigned pushed while the first pops.
    ready_in = 1'b0;
    drive(1'b1, 5'd6, 1'b1, 2'd1, 32'h0, 32'h80F0_7F81, 32'h0, 2'b00, 1'b0, 2'd3);
    tick;
    check("ld_byte", result, exp_b3s);
    ready_in = 1'b1;
    drive(1'b1, 5'd7, 1'b1, 2'd1, 32'h0, 32'h80F0_7F81, 32'h0, 2'b01, 1'b1, 2'd2);
    tick;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    check("ld_half", result, exp_h2u);
    check("ld_half_rdest", {27'b0, rdest_out}, 32'd7);
    check("ld_cnt", retire_cnt, 32'd2);
    tick;
    check("ld_cnt_after", retire_cnt, 32'd3);

    // rdest 0 suppresses regwrite; then an out-of-range select.
    ready_in = 1'b0;
    drive(1'b1, 5'd0, 1'b1, 2'd2, 32'h0, 32'h0, 32'h104, 2'd0, 1'b0, 2'd0);
    tick;
    check("r0_valid", {31'b0, valid_out}, 32'd1);
    check("r0_regwrite", {31'b0, regwrite_out}, 32'd0);
    check("r0_pc_result", result, 32'h104);
    ready_in = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 2'd3, 32'h11, 32'h22, 32'h33, 2'd0, 1'b0, 2'd0);
    tick;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    check("sel3_result", result, 32'd0);
    check("sel3_err", {31'b0, sel_err}, 32'd1);
    tick;
    check("sel3_cnt", retire_cnt, 32'd5);
    check("sel3_err_clear", {31'b0, sel_err}, 32'd0);

    // Backpressure: A and B fill the buffer, C is held until space opens.
    ready_in = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 2'd0, 32'hA, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick;
    check("bp_ready_1", {31'b0, ready_out}, 32'd1);
    drive(1'b1, 5'd2, 1'b1, 2'd0, 32'hB, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick;
    check("bp_ready_full", {31'b0, ready_out}, 32'd0);
    drive(1'b1, 5'd3, 1'b1, 2'd0, 32'hC, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick;
    check("bp_hold_ready", {31'b0, ready_out}, 32'd0);
    check("bp_head_A", result, 32'hA);
    ready_in = 1'b1;
    tick;
    check("bp_head_B", result, 32'hB);
    check("bp_ready_again", {31'b0, ready_out}, 32'd1);
    tick;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    check("bp_head_C", result, 32'hC);
    check("bp_rdest_C", {27'b0, rdest_out}, 32'd3);
    tick;
    check("bp_drained", {31'b0, valid_out}, 32'd0);
    check("bp_cnt", retire_cnt, 32'd8);

    // Asynchronous reset with two entries held.
    ready_in = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 2'd0, 32'hD, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick;
    drive(1'b1, 5'd4, 1'b1, 2'd0, 32'hE, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    check("pre_rst_full", {31'b0, ready_out}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, valid_out}, 32'd0);
    check("arst_ready", {31'b0, ready_out}, 32'd1);
    check("arst_cnt", retire_cnt, 32'd0);
    check("arst_result", result, 32'd0);
    #1 rst_n = 1'b1;
    ready_in = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 2'd0, 32'h77, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    tick;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
    check("post_rst_valid", {31'b0, valid_out}, 32'd1);
    check("post_rst_result", result, 32'h77);
    check("post_rst_rdest", {27'b0, rdest_out}, 32'd9);
    tick;
    check("post_rst_cnt", retire_cnt, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 Parameter NSRC, default 3: number of result sources (0 ALU, 1 memory, 2 PC+4).
REQ-002 Parameter DATA_W, default DATA_SIZE: result width.
REQ-003 Parameter DEPTH, default 2, legal >=2: buffer entries.
REQ-004 Parameter LD_SRC, default 1: source index that receives load extension.
REQ-005 i_aclk  in  1  single system clock; all state on rising edge.
REQ-006 i_areset_n  in  1  reset, asynchronous, active-low.
REQ-007 i_valid  in  1  upstream entry valid.
REQ-008 o_ready  out  1  block can accept an entry this cycle.
REQ-009 i_rdest  in  $clog2(NUM_REGS)  destination register.
REQ-010 i_regwrite  in  1  entry writes register file.
REQ-011 i_sel  in  $clog2(NSRC)  result source select.
REQ-012 i_src_data  in  NSRC*DATA_W  packed source data; source k at bits [k*DATA_W +: DATA_W].
REQ-013 i_ld_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-014 i_ld_unsigned  in  1  zero-extend when 1, sign-extend when 0.
REQ-015 i_ld_offset  in  2  byte offset of the load within the word.
REQ-016 o_valid  out  1  head entry presented.
REQ-017 i_ready  in  1  register file/consumer accepts head.
REQ-018 o_rdest  out  $clog2(NUM_REGS)  head destination.
REQ-019 o_regwrite  out  1  o_valid & head regwrite & (head rdest != 0).
REQ-020 o_wb_result  out  DATA_W  selected, extended result; 0 when o_valid=0.
REQ-021 o_sel_err  out  1  o_valid & head sel >= NSRC.
REQ-022 o_retire_cnt  out  32  count of popped entries.

Function
REQ-023 Push occurs when i_valid & o_ready; the entry stores rdest, regwrite, sel, all source data, and load fields.
REQ-024 o_ready shall be 1 exactly when occupancy < DEPTH; it is derived from registered occupancy only, with no combinational path from i_ready.
REQ-025 o_valid shall be 1 exactly when occupancy != 0; pop occurs when o_valid & i_ready.
REQ-026 Latency from push into an empty buffer to o_valid is 1 cycle.
REQ-027 Simultaneous push and pop leaves occupancy unchanged; order is strictly FIFO.
REQ-028 Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-029 o_wb_result is combinational from the head entry.
REQ-030 Load extension for sel==LD_SRC:
- byte: data[8*off +: 8]
- half: data[16*off[1] +: 16], with off[0] ignored
- then sign- or zero-extend to DATA_W.
REQ-031 If head sel >= NSRC, o_wb_result=0 and o_sel_err=1.
REQ-032 o_retire_cnt increments by 1 on each pop and wraps from 0xFFFFFFFF to 0.

Reset
REQ-033 On reset assertion:
- occupancy and pointers go to 0 and o_retire_cnt to 0, immediately, including mid-operation.
- Outputs: o_valid=0, o_regwrite=0, o_sel_err=0, o_wb_result=0, o_ready=1.
REQ-034 Entry storage is not reset; first push is accepted on the first clock after deassertion.

Configuration
REQ-035 Macro WB_LOADEXT_EN:
- defined: REQ-030 is implemented.
- undefined: source LD_SRC passes through unmodified, and i_ld_size, i_ld_unsigned and i_ld_offset are neither stored nor used.

Structure
REQ-036 multicore_pkg shall hold typedef wb_ldsize_t (LD_B, LD_H, LD_W) and constants WB_SRC_ALU=0, WB_SRC_MEM=1, WB_SRC_PC=2.
REQ-037 Sub-module wb_skid_fifo, parametrised by width and DEPTH, holds storage, pointers and occupancy; the source mux, extension and counter live in writeback_pipe.

Verification
REQ-038 Single push, empty buffer: sel=0, ALU=0x1234, rdest=5, i_ready=1 -> next cycle o_valid=1, o_wb_result=0x1234, o_regwrite=1, o_retire_cnt becomes 1.
REQ-039 Load extension (WB_LOADEXT_EN defined): mem=0x80F0_7F81, sel=1:
- byte, off=3, signed -> 0xFFFFFF80.
- half, off=2, unsigned -> 0x000080F0.
- Undefined macro -> 0x80F07F81.
REQ-040 Backpressure, DEPTH=2, i_ready=0: push A, B, C continuously -> o_ready=0 after 2 accepts and C is held; raise i_ready -> A, B, C retire in order, retire count 3.
REQ-041 rdest=0 with regwrite=1 -> o_valid=1, o_regwrite=0.
REQ-042 sel=3 with NSRC=3 -> o_wb_result=0, o_sel_err=1.
REQ-043 Reset asserted with 2 entries held -> o_valid=0, o_ready=1 and count=0 in the same cycle; after reset a fresh push is presented correctly.
